// File: rtl/program_loader.sv
// Framed byte-stream loader: packs big-endian bytes into 32-bit words, writes them to program memory
// and holds the CPU in reset until a complete image is accepted. Define LOADER_CHECKSUM_EN for a trailing XOR check byte.
module program_loader #(
    parameter int          MEMORY_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
    localparam logic [16:0]     DEPTH_LIM  = 17'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        S_CNT_HI = 3'd0,
        S_CNT_LO = 3'd1,
        S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK  = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic [7:0]    chk_r;
`endif

    state_t        state_r;
    logic [7:0]    cnt_hi_r;
    logic [15:0]   count_r;
    logic [23:0]   word_r;
    logic [1:0]    byte_idx_r;
    logic [TW-1:0] timer_r;
    logic          mem_we_r;
    logic [31:0]   mem_addr_r;
    logic [31:0]   mem_wdata_r;
    logic          cpu_hold_r;
    logic          load_done_r;
    logic          load_error_r;
    logic [15:0]   words_loaded_r;

    logic [15:0]   count_s;
    logic [31:0]   word_s;
    logic [15:0]   words_next_s;
    logic          timed_s;
    logic          expire_s;

    assign count_s      = {cnt_hi_r, rx_data};
    assign word_s       = {word_r, rx_data};
    assign words_next_s = words_loaded_r + 16'd1;
`ifdef LOADER_CHECKSUM_EN
    assign timed_s      = (state_r == S_CNT_LO) || (state_r == S_DATA) || (state_r == S_CHECK);
`else
    assign timed_s      = (state_r == S_CNT_LO) || (state_r == S_DATA);
`endif
    // An arriving byte always beats an expiring timer.
    assign expire_s     = timed_s && !rx_valid && (timer_r == TIMER_LAST);

    // Frame parser, word packer, inter-byte timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_CNT_HI;
            cnt_hi_r       <= 8'd0;
            count_r        <= 16'd0;
            word_r         <= 24'd0;
            byte_idx_r     <= 2'd0;
            timer_r        <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_r          <= 8'd0;
`endif
            mem_we_r       <= 1'b0;
            mem_addr_r     <= BASE_ADDR;
            mem_wdata_r    <= 32'd0;
            cpu_hold_r     <= 1'b1;
            load_done_r    <= 1'b0;
            load_error_r   <= 1'b0;
            words_loaded_r <= 16'd0;
        end else begin
            mem_we_r <= 1'b0;
            // Address steps past a word only once its write pulse has been presented.
            if (mem_we_r) begin
                mem_addr_r <= mem_addr_r + 32'd4;
            end
            if (timed_s && !rx_valid) begin
                timer_r <= timer_r + TIMER_ONE;
            end else begin
                timer_r <= '0;
            end

            if (expire_s) begin
                state_r      <= S_ERROR;
                load_error_r <= 1'b1;
                cpu_hold_r   <= 1'b1;
            end else begin
                case (state_r)
                    S_CNT_HI: begin
                        if (rx_valid) begin
                            cnt_hi_r <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                            chk_r    <= rx_data;
`endif
                            state_r  <= S_CNT_LO;
                        end
                    end
                    S_CNT_LO: begin
                        if (rx_valid) begin
                            count_r <= count_s;
`ifdef LOADER_CHECKSUM_EN
                            chk_r   <= chk_fold(chk_r, rx_data);
`endif
                            if ({1'b0, count_s} > DEPTH_LIM) begin
                                state_r      <= S_ERROR;
                                load_error_r <= 1'b1;
                                cpu_hold_r   <= 1'b1;
                            end else if (count_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state_r     <= S_CHECK;
`else
                                state_r     <= S_DONE;
                                load_done_r <= 1'b1;
                                cpu_hold_r  <= 1'b0;
`endif
                            end else begin
                                state_r <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            word_r     <= word_s[23:0];
                            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            chk_r      <= chk_fold(chk_r, rx_data);
`endif
                            if (byte_idx_r == 2'd3) begin
                                mem_we_r       <= 1'b1;
                                mem_wdata_r    <= word_s;
                                words_loaded_r <= words_next_s;
                                if (words_next_s == count_r) begin
`ifdef LOADER_CHECKSUM_EN
                                    state_r     <= S_CHECK;
`else
                                    state_r     <= S_DONE;
                                    load_done_r <= 1'b1;
                                    cpu_hold_r  <= 1'b0;
`endif
                                end
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (rx_valid) begin
                            if (rx_data == chk_r) begin
                                state_r     <= S_DONE;
                                load_done_r <= 1'b1;
                                cpu_hold_r  <= 1'b0;
                            end else begin
                                state_r      <= S_ERROR;
                                load_error_r <= 1'b1;
                                cpu_hold_r   <= 1'b1;
                            end
                        end
                    end
`endif
                    S_DONE: begin
                        state_r <= S_DONE;
                    end
                    S_ERROR: begin
                        state_r <= S_ERROR;
                    end
                    default: begin
                        state_r      <= S_ERROR;
                        load_error_r <= 1'b1;
                        cpu_hold_r   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign load_done    = load_done_r;
    assign load_error   = load_error_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of whole frames plus hand-written latency/timeout/reset sequences.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    program_loader #(
        .MEMORY_DEPTH   (256),
        .BASE_ADDR      (32'h0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  fbuf[0:1039];
    int          flen;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_flip = 8'h00;
`endif

    typedef struct {
        string       name;
        int          n;
        logic [95:0] bytes;
        logic        exp_done;
        logic        exp_err;
        int          exp_words;
        int          exp_writes;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_byte(fbuf[i]);
    endtask

    task automatic send_chk();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < flen; i++) c = c ^ fbuf[i];
        send_byte(c ^ chk_flip);
`endif
    endtask

    task automatic send_frame();
        send_range(0, flen);
        send_chk();
    endtask

    task automatic load_vec(input int v);
        flen = vecs[v].n;
        for (int i = 0; i < flen; i++) fbuf[i] = vecs[v].bytes[95-8*i -: 8];
    endtask

    initial begin
        int base;

        vecs[0] = '{"two_words", 10, {80'h0002_2008_0005_AC08_0000, 16'h0}, 1'b1, 1'b0, 2, 2,
                    {32'h20080005, 32'hAC080000}};
        vecs[1] = '{"oversize", 2, {16'h0101, 80'h0}, 1'b0, 1'b1, 0, 0, 64'h0};
        vecs[2] = '{"empty", 2, {16'h0000, 80'h0}, 1'b1, 1'b0, 0, 0, 64'h0};
        vecs[3] = '{"one_word", 6, {48'h0001_DEAD_BEEF, 48'h0}, 1'b1, 1'b0, 1, 1,
                    {32'hDEADBEEF, 32'h0}};
        vecs[4] = '{"huge_count", 2, {16'h8000, 80'h0}, 1'b0, 1'b1, 0, 0, 64'h0};

        // Reset state
        do_reset();
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);

        // Idle line before the frame never times out
        repeat (40) @(negedge clk);
        check("idle_no_error", 32'(load_error), 32'd0);

        // Table-driven whole frames
        for (int v = 0; v < 5; v++) begin
            do_reset();
            base = wr_addr_q.size();
            load_vec(v);
            send_frame();
            repeat (3) @(negedge clk);
            check({vecs[v].name, "_done"}, 32'(load_done), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_err"}, 32'(load_error), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_hold"}, 32'(cpu_hold), 32'(!vecs[v].exp_done));
            check({vecs[v].name, "_words"}, 32'(words_loaded), 32'(vecs[v].exp_words));
            check({vecs[v].name, "_nwr"}, 32'(wr_addr_q.size() - base), 32'(vecs[v].exp_writes));
            for (int k = 0; k < vecs[v].exp_writes; k++) begin
                if (base + k < wr_addr_q.size()) begin
                    check({vecs[v].name, "_addr"}, wr_addr_q[base+k], 32'(4*k));
                    check({vecs[v].name, "_data"}, wr_data_q[base+k], vecs[v].exp_data[63-32*k -: 32]);
                end
            end
        end

`ifdef LOADER_CHECKSUM_EN
        // Wrong check byte: words still written, image rejected
        do_reset();
        base = wr_addr_q.size();
        load_vec(0);
        chk_flip = 8'h01;
        send_frame();
        chk_flip = 8'h00;
        repeat (3) @(negedge clk);
        check("badchk_err", 32'(load_error), 32'd1);
        check("badchk_done", 32'(load_done), 32'd0);
        check("badchk_hold", 32'(cpu_hold), 32'd1);
        check("badchk_nwr", 32'(wr_addr_q.size() - base), 32'd2);
`endif

        // Write and release latency relative to the accepting byte
        do_reset();
        fbuf[0] = 8'h00; fbuf[1] = 8'h01; fbuf[2] = 8'h11; fbuf[3] = 8'h22; fbuf[4] = 8'h33; fbuf[5] = 8'h44;
        flen = 6;
        send_range(0, 5);
        check("lat_no_early_we", 32'(mem_we), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        @(negedge clk);
        rx_valid = 1'b0;
        check("lat_we", 32'(mem_we), 32'd1);
        check("lat_wdata", mem_wdata, 32'h11223344);
        check("lat_addr", mem_addr, 32'h0);
        check("lat_words", 32'(words_loaded), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        check("lat_hold_before_chk", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check("lat_we_low", 32'(mem_we), 32'd0);
        check("lat_addr_next", mem_addr, 32'h4);
        send_byte(8'h45);
        check("lat_hold", 32'(cpu_hold), 32'd0);
        check("lat_done", 32'(load_done), 32'd1);
`else
        check("lat_hold", 32'(cpu_hold), 32'd0);
        check("lat_done", 32'(load_done), 32'd1);
        @(negedge clk);
        check("lat_we_low", 32'(mem_we), 32'd0);
        check("lat_addr_next", mem_addr, 32'h4);
`endif

        // Timeout: 15 idle cycles tolerated, the 16th errors
        do_reset();
        base = wr_addr_q.size();
        fbuf[0] = 8'h00; fbuf[1] = 8'h01; fbuf[2] = 8'h20;
        send_range(0, 3);
        repeat (15) @(negedge clk);
        check("tmo_not_yet", 32'(load_error), 32'd0);
        @(negedge clk);
        check("tmo_err", 32'(load_error), 32'd1);
        check("tmo_hold", 32'(cpu_hold), 32'd1);
        check("tmo_nwr", 32'(wr_addr_q.size() - base), 32'd0);

        // Byte arriving on the expiry cycle wins
        do_reset();
        fbuf[0] = 8'h00; fbuf[1] = 8'h01; fbuf[2] = 8'hA1; fbuf[3] = 8'hB2; fbuf[4] = 8'hC3; fbuf[5] = 8'hD4;
        flen = 6;
        send_range(0, 2);
        repeat (15) @(negedge clk);
        send_range(2, 6);
        send_chk();
        repeat (2) @(negedge clk);
        check("expiry_byte_err", 32'(load_error), 32'd0);
        check("expiry_byte_done", 32'(load_done), 32'd1);
        check("expiry_byte_data", wr_data_q[wr_data_q.size()-1], 32'hA1B2C3D4);

        // Reset mid-frame, then a fresh frame loads from the base address
        do_reset();
        fbuf[0] = 8'h00; fbuf[1] = 8'h02;
        for (int i = 2; i < 7; i++) fbuf[i] = 8'(8'h50 + i);
        send_range(0, 7);
        do_reset();
        check("mid_rst_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        check("mid_rst_addr", mem_addr, 32'h0);
        base = wr_addr_q.size();
        for (int i = 0; i < 6; i++) fbuf[i] = 8'h00;
        fbuf[1] = 8'h01;
        flen = 6;
        send_frame();
        repeat (3) @(negedge clk);
        check("mid_rst_done", 32'(load_done), 32'd1);
        check("mid_rst_nwr", 32'(wr_addr_q.size() - base), 32'd1);
        if (wr_addr_q.size() > base) begin
            check("mid_rst_waddr", wr_addr_q[base], 32'h0);
            check("mid_rst_wdata", wr_data_q[base], 32'h0);
        end

        // Largest accepted image (N == MEMORY_DEPTH), bytes streamed back-to-back
        do_reset();
        base = wr_addr_q.size();
        fbuf[0] = 8'h01; fbuf[1] = 8'h00;
        for (int i = 0; i < 1024; i++) fbuf[2+i] = 8'(i);
        flen = 1026;
        send_frame();
        repeat (3) @(negedge clk);
        check("full_done", 32'(load_done), 32'd1);
        check("full_err", 32'(load_error), 32'd0);
        check("full_words", 32'(words_loaded), 32'd256);
        check("full_nwr", 32'(wr_addr_q.size() - base), 32'd256);
        if (wr_addr_q.size() >= base + 256) begin
            check("full_first", wr_data_q[base], 32'h00010203);
            check("full_last_addr", wr_addr_q[base+255], 32'h3FC);
            check("full_last_data", wr_data_q[base+255], 32'hFCFDFEFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
